// File: rtl/pwm_dac_bank_pkg.sv
// Shared types for the PWM/sigma-delta DAC bank.
// Holds the output-mode encoding and the decode that folds the reserved code onto edge-aligned PWM.
package pwm_dac_bank_pkg;

  typedef enum logic [1:0] {
    PWM_EDGE        = 2'd0,
    PWM_CENTRE      = 2'd1,
    PWM_SIGMA_DELTA = 2'd2
  } PWM_MODE;

  function automatic PWM_MODE decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return PWM_CENTRE;
      2'd2:    return PWM_SIGMA_DELTA;
      default: return PWM_EDGE;
    endcase
  endfunction

endpackage

// File: rtl/pwm_dac_bank_channel.sv
// One DAC channel: PWM comparator plus first-order sigma-delta accumulator.
// Registered output, 1 cycle after cnt; no backpressure.
module pwm_dac_channel
  import pwm_dac_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic             en,
  input  logic             clear,
  input  PWM_MODE          mode,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  output logic             raw
);

  logic [WIDTH-1:0] acc_q, acc_d, acc_in;
  logic [WIDTH:0]   sum;
  logic             raw_q, raw_d;

  always_comb begin
    // clear restarts the accumulator from 0 in the current cycle
    acc_in = clear ? '0 : acc_q;
    sum    = {1'b0, acc_in} + {1'b0, duty};
    acc_d  = '0;
    raw_d  = 1'b0;
    if (en) begin
      if (mode == PWM_SIGMA_DELTA) begin
        acc_d = sum[WIDTH-1:0];
        raw_d = sum[WIDTH];
      end else begin
        raw_d = (cnt < duty);
      end
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      acc_q <= '0;
      raw_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      raw_q <= raw_d;
    end
  end

  assign raw = raw_q;

endmodule

// File: rtl/pwm_dac_bank.sv
// Multi-channel PWM/sigma-delta DAC bank on one shared counter; duty words double-buffered to period boundaries.
// Outputs registered 1 cycle after the counter; opDutyReady low while a captured word waits for the next boundary.
module pwm_dac_bank
  import pwm_dac_bank_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                      ipClk,
  input  logic                      ipReset,
  input  logic                      ipEnable,
  input  logic [1:0]                ipMode,
  input  logic [CHANNELS*WIDTH-1:0] ipDuty,
  input  logic                      ipDutyValid,
  output logic                      opDutyReady,
  output logic                      opPeriodStart,
  output logic [CHANNELS-1:0]       opPWM
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             down_q, down_d;
  PWM_MODE          mode_q, mode_d, mode_in, mode_eff;
  logic             pend_full_q, pend_full_d;
  logic             start_q, start_d;
  logic             boundary, mode_chg, accept, chan_clear;
  logic [WIDTH-1:0] duty_in;
  logic [WIDTH-1:0] pend_q   [CHANNELS];
  logic [WIDTH-1:0] pend_d   [CHANNELS];
  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];
  logic [WIDTH-1:0] duty_eff [CHANNELS];

  always_comb begin
    mode_in    = decode_mode(ipMode);
    // cnt==0 only ever occurs at the start of the up-count, so one test covers all modes
    boundary   = ipEnable && (cnt_q == '0);
    mode_eff   = boundary ? mode_in : mode_q;
    mode_chg   = boundary && (mode_in != mode_q);
    chan_clear = !ipEnable || mode_chg;
    accept     = ipDutyValid && !pend_full_q;

    pend_full_d = pend_full_q;
    mode_d      = mode_q;
    pend_d      = pend_q;
    shadow_d    = shadow_q;
    duty_in     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      duty_in = ipDuty[k*WIDTH +: WIDTH];
      if (SIGNED_IN) duty_in[WIDTH-1] = ~duty_in[WIDTH-1];
      if (accept) pend_d[k] = duty_in;
      // the boundary cycle already uses the words it promotes
      duty_eff[k] = (boundary && pend_full_q) ? pend_q[k] : shadow_q[k];
    end
    if (accept) pend_full_d = 1'b1;
    if (boundary) begin
      mode_d = mode_in;
      if (pend_full_q) begin
        shadow_d    = pend_q;
        pend_full_d = 1'b0;
      end
    end

    cnt_d  = '0;
    down_d = 1'b0;
    if (ipEnable) begin
      if (mode_eff == PWM_CENTRE) begin
        if (down_q) begin
          cnt_d  = cnt_q - WIDTH'(1);
          down_d = (cnt_q != WIDTH'(1));
        end else if (cnt_q == CNT_MAX) begin
          cnt_d  = CNT_MAX - WIDTH'(1);
          down_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
    start_d = boundary;
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      cnt_q       <= '0;
      down_q      <= 1'b0;
      mode_q      <= PWM_EDGE;
      pend_full_q <= 1'b0;
      start_q     <= 1'b0;
      pend_q      <= '{default: '0};
      shadow_q    <= '{default: '0};
    end else begin
      cnt_q       <= cnt_d;
      down_q      <= down_d;
      mode_q      <= mode_d;
      pend_full_q <= pend_full_d;
      start_q     <= start_d;
      pend_q      <= pend_d;
      shadow_q    <= shadow_d;
    end
  end

  assign opDutyReady   = ~pend_full_q;
  assign opPeriodStart = start_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_dac_channel #(.WIDTH(WIDTH)) u_ch (
      .ipClk   (ipClk),
      .ipReset (ipReset),
      .en      (ipEnable),
      .clear   (chan_clear),
      .mode    (mode_eff),
      .cnt     (cnt_q),
      .duty    (duty_eff[g]),
      .raw     (opPWM[g])
    );
  end

endmodule

// File: tb/tb_pwm_dac_bank.sv
// Bench for pwm_dac_bank: unsigned DUT (index 0) and signed-input DUT (index 1), two channels of 4 bits each.
// Waveforms per period are predicted from the mode rules and compared as bit vectors.
module tb_pwm_dac_bank;

  localparam int N  = 16;
  localparam int NC = 30;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]      en, vld;
  logic [1:0][1:0] mode;
  logic [1:0][7:0] duty;
  logic [1:0]      pwm_a, pwm_b;
  logic            rdy_a, rdy_b, st_a, st_b;
  logic [1:0][1:0] pwm;
  logic [1:0]      rdy, st;

  int n_checks = 0;
  int n_fail   = 0;

  assign pwm[0] = pwm_a;
  assign pwm[1] = pwm_b;
  assign rdy    = {rdy_b, rdy_a};
  assign st     = {st_b, st_a};

  always #5 clk = ~clk;

  pwm_dac_bank #(.CHANNELS(2), .WIDTH(4), .SIGNED_IN(1'b0)) u_dut (
    .ipClk(clk), .ipReset(rst_n), .ipEnable(en[0]), .ipMode(mode[0]), .ipDuty(duty[0]),
    .ipDutyValid(vld[0]), .opDutyReady(rdy_a), .opPeriodStart(st_a), .opPWM(pwm_a));

  pwm_dac_bank #(.CHANNELS(2), .WIDTH(4), .SIGNED_IN(1'b1)) u_dut_s (
    .ipClk(clk), .ipReset(rst_n), .ipEnable(en[1]), .ipMode(mode[1]), .ipDuty(duty[1]),
    .ipDutyValid(vld[1]), .opDutyReady(rdy_b), .opPeriodStart(st_b), .opPWM(pwm_b));

  // Reference waveforms, sample i = i-th output cycle of a period
  function automatic logic [31:0] exp_edge(input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (i < d);
    return r;
  endfunction

  function automatic logic [31:0] exp_centre(input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < NC; i++) r[i] = (((i < N) ? i : NC - i) < d);
    return r;
  endfunction

  // accumulator started from 0: a one whenever floor(t*d/2^W) steps up
  function automatic logic [31:0] exp_sd(input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (((i + 1) * d) / N) != ((i * d) / N);
    return r;
  endfunction

  function automatic int off(input int raw4);
    return (raw4 >= 8) ? (raw4 - 16) + 8 : raw4 + 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int s, input string tag);
    int i = 0;
    while (st[s] !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(st[s]), 32'd1);
  endtask

  task automatic write_duty(input int s, input int d0, input int d1);
    int i = 0;
    duty[s] = {4'(d1), 4'(d0)};
    vld[s]  = 1'b1;
    while (rdy[s] !== 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("duty_accept", 32'(rdy[s]), 32'd1);
    @(negedge clk);
    vld[s] = 1'b0;
  endtask

  task automatic grab(input int s, input int n, output logic [31:0] v0,
                      output logic [31:0] v1, output logic [31:0] sv);
    v0 = '0; v1 = '0; sv = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        vld[s] = 1'b0;
      end
      v0[i] = pwm[s][0];
      v1[i] = pwm[s][1];
      sv[i] = st[s];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v0, v1, sv, e;
    int d0, d1, a0, a1, b0, b1, i;

    rst_n = 1'b0; en = '0; vld = '0; mode = '0; duty = '0;
    repeat (2) @(negedge clk);
    chk("reset_pwm", 32'(pwm_a), 32'd0);
    chk("reset_start", 32'(st_a), 32'd0);
    chk("reset_ready", 32'(rdy_a), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // edge-aligned, duty {3,0}
    write_duty(0, 3, 0);
    chk("ready_low_after_write", 32'(rdy_a), 32'd0);
    en[0] = 1'b1;
    wait_start(0, "t1_start");
    grab(0, N, v0, v1, sv);
    chk("t1_ch0", v0, exp_edge(3));
    chk("t1_ch1", v1, exp_edge(0));
    chk("t1_starts", sv, 32'd1);
    @(negedge clk);
    chk("t1_period16", 32'(st_a), 32'd1);

    for (int it = 0; it < 3; it++) begin
      d0 = int'($urandom_range(15, 0));
      d1 = int'($urandom_range(15, 0));
      repeat (2) @(negedge clk);
      write_duty(0, d0, d1);
      wait_start(0, "edge_start");
      grab(0, N, v0, v1, sv);
      chk("edge_ch0", v0, exp_edge(d0));
      chk("edge_ch1", v1, exp_edge(d1));
      chk("edge_starts", sv, 32'd1);
    end

    // centre-aligned
    for (int it = 0; it < 3; it++) begin
      d0 = (it == 0) ? 5 : int'($urandom_range(15, 1));
      d1 = int'($urandom_range(15, 0));
      repeat (2) @(negedge clk);
      mode[0] = 2'b01;
      write_duty(0, d0, d1);
      wait_start(0, "centre_start");
      grab(0, NC, v0, v1, sv);
      chk("centre_ch0", v0, exp_centre(d0));
      chk("centre_ch1", v1, exp_centre(d1));
      chk("centre_starts", sv, 32'd1);
      @(negedge clk);
      chk("centre_period30", 32'(st_a), 32'd1);
    end

    // sigma-delta, each entry through a mode change; reserved code 3 acts as edge
    for (int it = 0; it < 3; it++) begin
      if (it > 0) begin
        a0 = int'($urandom_range(15, 0));
        a1 = int'($urandom_range(15, 0));
        repeat (2) @(negedge clk);
        mode[0] = 2'b11;
        write_duty(0, a0, a1);
        wait_start(0, "rsvd_start");
        grab(0, N, v0, v1, sv);
        chk("rsvd_edge_ch0", v0, exp_edge(a0));
        chk("rsvd_edge_ch1", v1, exp_edge(a1));
      end
      d0 = (it == 0) ? 4 : int'($urandom_range(15, 0));
      d1 = int'($urandom_range(15, 0));
      repeat (2) @(negedge clk);
      mode[0] = 2'b10;
      write_duty(0, d0, d1);
      wait_start(0, "sd_start");
      grab(0, N, v0, v1, sv);
      chk("sd_ch0", v0, exp_sd(d0));
      chk("sd_ch1", v1, exp_sd(d1));
      @(negedge clk);
      grab(0, N, v0, v1, sv);
      chk("sd_p2_starts", sv, 32'd1);
      chk("sd_p2_ch0", v0, exp_sd(d0));
      chk("sd_p2_ch1", v1, exp_sd(d1));
    end

    // handshake: A mid-period, B stalls until the boundary
    d0 = int'($urandom_range(15, 0));
    d1 = int'($urandom_range(15, 0));
    repeat (2) @(negedge clk);
    mode[0] = 2'b00;
    write_duty(0, d0, d1);
    wait_start(0, "hs_pre_start");
    grab(0, N, v0, v1, sv);
    chk("hs_pre_ch0", v0, exp_edge(d0));
    a0 = int'($urandom_range(15, 0)); a1 = int'($urandom_range(15, 0));
    b0 = int'($urandom_range(15, 0)); b1 = int'($urandom_range(15, 0));
    repeat (3) @(negedge clk);
    chk("hs_ready_before_A", 32'(rdy_a), 32'd1);
    duty[0] = {4'(a1), 4'(a0)};
    vld[0]  = 1'b1;
    @(negedge clk);
    chk("hs_ready_drops", 32'(rdy_a), 32'd0);
    duty[0] = {4'(b1), 4'(b0)};
    i = 0;
    while (rdy_a !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("hs_B_released_at_boundary", 32'(st_a), 32'd1);
    grab(0, N, v0, v1, sv);
    chk("hs_A_ch0", v0, exp_edge(a0));
    chk("hs_A_ch1", v1, exp_edge(a1));
    chk("hs_B_pending", 32'(rdy_a), 32'd0);
    @(negedge clk);
    grab(0, N, v0, v1, sv);
    chk("hs_B_starts", sv, 32'd1);
    chk("hs_B_ch0", v0, exp_edge(b0));
    chk("hs_B_ch1", v1, exp_edge(b1));

    // enable drop and re-enable, then async reset mid-period
    repeat (2) @(negedge clk);
    write_duty(0, 15, 9);
    wait_start(0, "t6_start");
    grab(0, N, v0, v1, sv);
    chk("t6_ch0", v0, exp_edge(15));
    repeat (3) @(negedge clk);
    chk("t6_pwm_before_disable", 32'(pwm_a[0]), 32'd1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("t6_pwm_off", 32'(pwm_a), 32'd0);
    chk("t6_start_off", 32'(st_a), 32'd0);
    repeat (5) @(negedge clk);
    chk("t6_pwm_held_off", 32'(pwm_a), 32'd0);
    write_duty(0, 6, 2);
    chk("t6_hs_while_disabled", 32'(rdy_a), 32'd0);
    en[0] = 1'b1;
    @(negedge clk);
    chk("t6_reenable_start", 32'(st_a), 32'd1);
    grab(0, N, v0, v1, sv);
    chk("t6_reen_ch0", v0, exp_edge(6));
    chk("t6_reen_ch1", v1, exp_edge(2));
    repeat (3) @(negedge clk);
    write_duty(0, 11, 11);
    chk("t6_pending_before_reset", 32'(rdy_a), 32'd0);
    chk("t6_pwm_before_reset", 32'(pwm_a[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pwm", 32'(pwm_a), 32'd0);
    chk("t6_async_ready", 32'(rdy_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(0, "t6_post_reset_start");
    grab(0, N, v0, v1, sv);
    chk("t6_post_reset_ch0", v0, 32'd0);
    chk("t6_post_reset_ch1", v1, 32'd0);
    chk("t6_post_reset_ready", 32'(rdy_a), 32'd1);

    // signed-input DUT
    write_duty(1, 8, 7);
    en[1] = 1'b1;
    wait_start(1, "t5_start");
    grab(1, N, v0, v1, sv);
    chk("t5_min_ch0", v0, exp_edge(off(8)));
    chk("t5_max_ch1", v1, exp_edge(off(7)));
    d0 = int'($urandom_range(15, 0));
    d1 = int'($urandom_range(15, 0));
    repeat (2) @(negedge clk);
    write_duty(1, d0, d1);
    wait_start(1, "t5_rand_start");
    grab(1, N, v0, v1, sv);
    chk("t5_rand_ch0", v0, exp_edge(off(d0)));
    chk("t5_rand_ch1", v1, exp_edge(off(d1)));
    @(negedge clk);
    grab(1, 6, v0, v1, sv);
    e = exp_edge(off(d0)) & 32'h3F;
    chk("t5_pre_change_starts", sv, 32'd1);
    chk("t5_pre_change_ch0", v0, e);
    mode[1] = 2'b01;
    @(negedge clk);
    grab(1, 10, v0, v1, sv);
    e = (exp_edge(off(d0)) >> 6) & 32'h3FF;
    chk("t5_post_change_ch0", v0, e);
    chk("t5_no_early_start", sv, 32'd0);
    @(negedge clk);
    chk("t5_boundary_at_16", 32'(st_b), 32'd1);
    grab(1, NC, v0, v1, sv);
    chk("t5_centre_ch0", v0, exp_centre(off(d0)));
    chk("t5_centre_ch1", v1, exp_centre(off(d1)));
    chk("t5_centre_starts", sv, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
